// File: rtl/dmem_store_monitor.sv
// Data memory with a store monitor that turns the first mailbox/illegal store, or a timeout, into a sticky verdict.
// Optional 8-entry store log, built only when STORE_LOG_EN is defined.
module dmem_store_monitor #(
    parameter int PASS_ADDR      = 84,
    parameter int PASS_DATA      = 7,
    parameter int SCRATCH_ADDR   = 80,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [15:0] store_count,
    input  logic [2:0]  log_idx,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);

    localparam logic [31:0] PASS_ADDR_W    = 32'(PASS_ADDR);
    localparam logic [31:0] PASS_DATA_W    = 32'(PASS_DATA);
    localparam logic [31:0] SCRATCH_ADDR_W = 32'(SCRATCH_ADDR);
    localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  fail_code_reg, fail_code_next;
    logic [31:0] cycle_reg;
    logic [15:0] store_count_reg;
    logic        accept, aligned, commit;

    logic [31:0] mem [0:63];

    assign accept  = memwrite && (state_reg == ST_RUN);
    assign aligned = (dataadr[1:0] == 2'b00);
    // Misaligned stores only produce a verdict; they never touch RAM, the count or the log.
    assign commit  = accept && aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            fail_code_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            fail_code_reg <= fail_code_next;
        end
    end

    // A store verdict takes precedence over a timeout landing on the same edge.
    always_comb begin
        state_next     = state_reg;
        fail_code_next = fail_code_reg;
        if (state_reg == ST_RUN) begin
            if (accept && dataadr == PASS_ADDR_W) begin
                if (writedata == PASS_DATA_W) begin
                    state_next = ST_PASS;
                end else begin
                    state_next     = ST_FAIL;
                    fail_code_next = 2'd1;
                end
            end else if (accept && (!aligned || dataadr != SCRATCH_ADDR_W)) begin
                state_next     = ST_FAIL;
                fail_code_next = 2'd2;
            end else if (cycle_reg == TIMEOUT_LAST) begin
                state_next     = ST_FAIL;
                fail_code_next = 2'd3;
            end
        end
    end

    always_comb begin
        done      = (state_reg != ST_RUN);
        pass      = (state_reg == ST_PASS);
        fail_code = fail_code_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_reg       <= 32'd0;
            store_count_reg <= 16'd0;
        end else begin
            if (state_reg == ST_RUN) begin
                cycle_reg <= cycle_reg + 32'd1;
            end
            if (commit && store_count_reg != 16'hFFFF) begin
                store_count_reg <= store_count_reg + 16'd1;
            end
        end
    end

    assign store_count = store_count_reg;

    // RAM is deliberately left out of reset so a program image survives it.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            mem[dataadr[7:2]] <= writedata;
        end
    end

    assign readdata = mem[dataadr[7:2]];

`ifdef STORE_LOG_EN
    logic [31:0] log_addr_mem [0:7];
    logic [31:0] log_data_mem [0:7];
    logic [2:0]  wptr_reg;
    logic [2:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_reg <= 3'd0;
        end else if (commit) begin
            wptr_reg <= wptr_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            log_addr_mem[wptr_reg] <= dataadr;
            log_data_mem[wptr_reg] <= writedata;
        end
    end

    // 3-bit arithmetic gives the modulo-8 walk back from the newest entry.
    assign rd_ptr   = wptr_reg - 3'd1 - log_idx;
    assign log_addr = log_addr_mem[rd_ptr];
    assign log_data = log_data_mem[rd_ptr];
`else
    logic unused_log_idx;
    assign unused_log_idx = ^log_idx;
    assign log_addr = 32'd0;
    assign log_data = 32'd0;
`endif

endmodule
